// File: rtl/obstacle_scheduler_pkg.sv
// Shared game definitions: obstacle kinds, scheduler states, LFSR constants.
package obstacle_scheduler_pkg;

    typedef enum logic [1:0] {
        SMALL_CACTUS = 2'd0,
        LARGE_CACTUS = 2'd1,
        BIRD         = 2'd2
    } obstacle_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_GAP   = 2'd2,
        S_SPAWN = 2'd3
    } sched_state_t;

    localparam logic [7:0] LFSR_LOCKUP = 8'hFF;

    function automatic obstacle_t map_type(input logic [1:0] r,
                                           input logic       bird);
        obstacle_t t;
        t = SMALL_CACTUS;
        unique case (1'b1)
            !r[1]:         t = SMALL_CACTUS;
            r[1] && !r[0]: t = LARGE_CACTUS;
            r[1] && r[0]:  t = bird ? BIRD : LARGE_CACTUS;
            default:       t = SMALL_CACTUS;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/obstacle_scheduler.sv
// Spawn scheduler: waits a random tick gap, then offers one obstacle
// to the manager through a valid/ready handshake.
module obstacle_scheduler #(
    parameter logic [7:0] MIN_GAP  = 8'd40,
    parameter logic [7:0] GAP_MASK = 8'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_run,
    input  logic       tick,
    input  logic [1:0] level,
    input  logic       bird_en,
    input  logic [7:0] lfsr_q,
    output logic       lfsr_en,
    output logic       lfsr_clr,
    output logic       spawn_valid,
    input  logic       spawn_ready,
    output logic [1:0] spawn_type,
    output logic [7:0] spawn_count
);

    import obstacle_scheduler_pkg::*;

    sched_state_t state_q, state_d;
    logic [7:0]   gap_cnt_q, gap_cnt_d;
    obstacle_t    type_q, type_d;
    logic [7:0]   count_q, count_d;

    logic lock;
    logic en_raw;

    assign lock = (lfsr_q == LFSR_LOCKUP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= 8'd0;
            type_q    <= SMALL_CACTUS;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            type_q    <= type_d;
            count_q   <= count_d;
        end
    end

    // Dropping game_run wins over everything, including a handshake.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        type_d    = type_q;
        count_d   = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (game_run) begin
                    state_d = S_LOAD;
                    count_d = 8'd0;
                end
            end
            S_LOAD: begin
                if (!game_run) begin
                    state_d = S_IDLE;
                end else if (!lock) begin
                    gap_cnt_d = MIN_GAP + ((lfsr_q & GAP_MASK) >> level);
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (!game_run) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (gap_cnt_q == 8'd1) begin
                        state_d = S_SPAWN;
                        type_d  = map_type(lfsr_q[1:0], bird_en);
                    end else begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                end
            end
            S_SPAWN: begin
                if (!game_run) begin
                    state_d = S_IDLE;
                end else if (spawn_ready) begin
                    count_d = count_q + 8'd1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_raw      = 1'b0;
        spawn_valid = 1'b0;
        unique case (state_q)
            S_IDLE:  en_raw = 1'b1;
            S_LOAD:  en_raw = game_run;
            S_GAP:   en_raw = 1'b0;
            S_SPAWN: begin
                spawn_valid = 1'b1;
                en_raw      = game_run && spawn_ready;
            end
            default: en_raw = 1'b0;
        endcase
    end

    // Both LFSR controls are held off while reset is asserted.
    assign lfsr_clr    = reset && lock;
    assign lfsr_en     = reset && !lock && en_raw;
    assign spawn_type  = type_q;
    assign spawn_count = count_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: directed gap/type vectors,
// lock-up, abort, counter wrap and asynchronous reset.
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       game_run = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] level = 2'd0;
    logic       bird_en = 1'b0;
    logic [7:0] lfsr_q = 8'h12;
    logic       spawn_ready = 1'b0;
    logic       lfsr_en;
    logic       lfsr_clr;
    logic       spawn_valid;
    logic [1:0] spawn_type;
    logic [7:0] spawn_count;

    obstacle_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .game_run    (game_run),
        .tick        (tick),
        .level       (level),
        .bird_en     (bird_en),
        .lfsr_q      (lfsr_q),
        .lfsr_en     (lfsr_en),
        .lfsr_clr    (lfsr_clr),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_type  (spawn_type),
        .spawn_count (spawn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         gap;
        logic [1:0] typ;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts ticks since the gap was loaded and checks each offered spawn.
    initial begin
        int   tick_seen;
        logic prev_valid;
        exp_t cur;
        tick_seen  = 0;
        prev_valid = 1'b0;
        cur        = '{0, 2'd0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                tick_seen  = 0;
                prev_valid = 1'b0;
            end else begin
                if (spawn_valid && !prev_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_spawn", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("gap_ticks", tick_seen, cur.gap);
                        check("spawn_type", int'(spawn_type), int'(cur.typ));
                    end
                end else if (spawn_valid) begin
                    check("type_hold", int'(spawn_type), int'(cur.typ));
                end
                if (lfsr_en && !spawn_valid)
                    tick_seen = 0;
                else if (tick && !spawn_valid && game_run)
                    tick_seen++;
                prev_valid = spawn_valid;
            end
        end
    end

    task automatic spawn_once(input logic [7:0] ld, input logic [1:0] lv,
                              input logic [7:0] tv, input logic be,
                              input int egap, input logic [1:0] etyp,
                              input int hold, input bit abort);
        level   = lv;
        bird_en = be;
        lfsr_q  = ld;
        sb.push_back('{egap, etyp});
        #1;
        check("load_en", int'(lfsr_en), 1);
        @(posedge clk) #1;
        lfsr_q = tv;
        for (int i = 0; i < 400; i++) begin
            tick = 1'b1;
            @(posedge clk) #1;
            tick = 1'b0;
            if (spawn_valid) break;
            @(posedge clk) #1;
        end
        check("spawn_seen", int'(spawn_valid), 1);
        for (int i = 0; i < hold; i++) begin
            lfsr_q = lfsr_q ^ 8'h5A;
            tick   = ~tick;
            check("spawn_en_low", int'(lfsr_en), 0);
            @(posedge clk) #1;
        end
        tick   = 1'b0;
        lfsr_q = tv;
        if (abort) begin
            game_run    = 1'b0;
            spawn_ready = 1'b1;
            @(posedge clk) #1;
            spawn_ready = 1'b0;
            check("abort_valid", int'(spawn_valid), 0);
            check("abort_count", int'(spawn_count), int'(exp_cnt));
            check("abort_idle_en", int'(lfsr_en), 1);
        end else begin
            spawn_ready = 1'b1;
            #1;
            check("hs_en", int'(lfsr_en), 1);
            @(posedge clk) #1;
            spawn_ready = 1'b0;
            exp_cnt     = exp_cnt + 8'd1;
            check("count", int'(spawn_count), int'(exp_cnt));
            check("valid_drop", int'(spawn_valid), 0);
        end
    endtask

    initial begin
        lfsr_q = 8'hFF;
        #12;
        check("rst_en", int'(lfsr_en), 0);
        check("rst_clr", int'(lfsr_clr), 0);
        check("rst_valid", int'(spawn_valid), 0);
        check("rst_count", int'(spawn_count), 0);
        check("rst_type", int'(spawn_type), 0);
        lfsr_q = 8'h12;
        @(posedge clk) #1;
        reset = 1'b1;
        @(posedge clk) #1;
        check("idle_en", int'(lfsr_en), 1);
        check("idle_valid", int'(spawn_valid), 0);
        lfsr_q = 8'hFF;
        #1;
        check("idle_clr", int'(lfsr_clr), 1);
        check("idle_clr_en", int'(lfsr_en), 0);
        lfsr_q   = 8'h12;
        game_run = 1'b1;
        @(posedge clk) #1;

        spawn_once(8'h05, 2'd0, 8'h00, 1'b0, 45, 2'd0, 0, 1'b0);
        spawn_once(8'h3F, 2'd3, 8'h03, 1'b0, 47, 2'd1, 20, 1'b0);
        spawn_once(8'h3F, 2'd0, 8'h03, 1'b1, 103, 2'd2, 2, 1'b0);

        lfsr_q = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            check("lock_clr", int'(lfsr_clr), 1);
            check("lock_en", int'(lfsr_en), 0);
            check("lock_valid", int'(spawn_valid), 0);
        end
        spawn_once(8'h00, 2'd1, 8'h02, 1'b0, 40, 2'd1, 1, 1'b0);

        spawn_once(8'h01, 2'd2, 8'h01, 1'b0, 40, 2'd0, 1, 1'b1);

        lfsr_q   = 8'h12;
        game_run = 1'b1;
        @(posedge clk) #1;
        exp_cnt = 8'd0;
        check("restart_count", int'(spawn_count), 0);
        for (int n = 0; n < 256; n++)
            spawn_once(8'h00, 2'd3, 8'h01, 1'b0, 40, 2'd0, 0, 1'b0);
        check("wrap_count", int'(spawn_count), 0);

        spawn_once(8'h07, 2'd1, 8'h03, 1'b1, 43, 2'd2, 0, 1'b0);

        lfsr_q = 8'h05;
        @(posedge clk) #1;
        lfsr_q = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            @(posedge clk) #1;
            tick = 1'b0;
        end
        check("gap_clr", int'(lfsr_clr), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_en", int'(lfsr_en), 0);
        check("arst_clr", int'(lfsr_clr), 0);
        check("arst_valid", int'(spawn_valid), 0);
        check("arst_count", int'(spawn_count), 0);
        check("arst_type", int'(spawn_type), 0);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 The block SHALL have parameter MIN_GAP, default 8'd40: minimum ticks between spawns; legal range 1..255.
REQ-002 The block SHALL have parameter GAP_MASK, default 8'h3F: mask applied to the random gap term; MIN_GAP+GAP_MASK SHALL NOT exceed 255.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 game_run  in  1  high while the game is running.
REQ-006 tick  in  1  one-cycle game-frame pulse.
REQ-007 level  in  2  speed level 0..3; a higher level gives shorter random gaps.
REQ-008 bird_en  in  1  allows bird obstacles.
REQ-009 lfsr_q  in  8  current value of the external 8-bit XNOR LFSR (taps 7,3).
REQ-010 lfsr_en  out  1  advance enable for the LFSR.
REQ-011 lfsr_clr  out  1  synchronous clear request to the LFSR (drives its active-high reset).
REQ-012 spawn_valid  out  1  a spawn request is pending.
REQ-013 spawn_ready  in  1  the obstacle manager accepts the pending spawn.
REQ-014 spawn_type  out  2  obstacle type: 0 small cactus, 1 large cactus, 2 bird; 3 is never driven.
REQ-015 spawn_count  out  8  number of accepted spawns since the run started.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, GAP and SPAWN.
REQ-017 IDLE: lfsr_en=1 every cycle (entropy from start timing); a cycle with game_run=1 → LOAD, with spawn_count cleared to 0 on that transition.
REQ-018 LOAD: if lfsr_q==8'hFF, stay in LOAD with lfsr_en=0.
REQ-019 LOAD, lfsr_q≠8'hFF: gap_cnt <= MIN_GAP + ((lfsr_q & GAP_MASK) >> level), 8-bit, no overflow by REQ-002; lfsr_en=1 for that one cycle; → GAP.
REQ-020 GAP: on tick with gap_cnt==1 → SPAWN; on any other tick, gap_cnt decrements; no change without tick; spawn therefore follows exactly the loaded number of ticks.
REQ-021 On GAP→SPAWN, spawn_type SHALL be registered from lfsr_q[1:0]: 00/01→0, 10→1, 11→2 if bird_en=1 else 1.
REQ-022 SPAWN: spawn_valid=1 and spawn_type SHALL hold stable until handshake; ticks are ignored; lfsr_en=0 except on the handshake cycle.
REQ-023 Handshake SHALL occur on a cycle with spawn_valid=1 and spawn_ready=1: lfsr_en=1, spawn_count increments (wraps 255→0), → LOAD.
REQ-024 spawn_valid SHALL be 0 in every state other than SPAWN; spawn_ready is ignored outside SPAWN.
REQ-025 game_run=0 in any non-IDLE state → IDLE next cycle: a pending spawn_valid drops without handshake and spawn_count holds its value.
REQ-026 game_run=0 SHALL take priority over a simultaneous handshake: no increment.
REQ-027 lfsr_clr = (lfsr_q==8'hFF), combinational, in every state; the LFSR leaves its lock-up state within one cycle.
REQ-028 lfsr_en SHALL be 0 whenever lfsr_clr=1.

Reset
REQ-029 On reset low, asynchronously: state=IDLE, gap_cnt=0, spawn_type=0, spawn_count=0, spawn_valid=0.
REQ-030 During reset, lfsr_en=0 and lfsr_clr=0.
REQ-031 Release of reset SHALL be synchronous to clk; the first active edge evaluates IDLE.
REQ-032 Reset mid-SPAWN SHALL drop spawn_valid immediately.

Structure
REQ-033 A shared game package SHALL hold the obstacle-type enum (SMALL_CACTUS=0, LARGE_CACTUS=1, BIRD=2), the FSM state typedef, and the LFSR lock-up constant 8'hFF.
REQ-034 The block SHALL contain no sub-module; the LFSR is instantiated beside it in the parent, with lfsr_en→enable and lfsr_clr→reset.

Verification
REQ-035 Basic spawn: reset, game_run=1, lfsr_q=8'h05 at LOAD, level=0 → gap 45; spawn_valid rises after the 45th tick; spawn_ready one cycle later → spawn_count=1, state LOAD.
REQ-036 Level scaling: lfsr_q=8'h3F, level=3 → gap 40+7=47 ticks.
REQ-037 Level 0 with lfsr_q=8'h3F → gap 103 ticks.
REQ-038 Type mapping: lfsr_q[1:0]=11, bird_en=0 → spawn_type=1; bird_en=1 → 2.
REQ-039 Type hold: spawn_type holds with spawn_ready=0 for 20 cycles while lfsr_q and tick toggle.
REQ-040 Lock-up: lfsr_q=8'hFF in LOAD → lfsr_clr=1, lfsr_en=0, state stays LOAD; lfsr_q=8'h00 next → gap 40, → GAP.
REQ-041 Abort: game_run falls during SPAWN together with spawn_ready=1 → spawn_valid=0 next cycle, IDLE, spawn_count unchanged.
REQ-042 Wrap/reset: 256 accepted spawns → spawn_count=0; async reset asserted mid-GAP → all outputs at REQ-029/REQ-030 values without a clock edge.
